gpu_command_queue: RTL and testbench

Buffers 32-bit drawing instructions written by the ARMv4 core and issues them to the graphics processing unit's `INS` input, one instruction per video frame. It sits directly upstream of the GPU and changes `INS` only at the start of vertical sync, so the GPU never sees an instruction change mid-frame. When no instruction is pending it drives `INS = 0` (NOP).

---
 rtl/gpu_command_queue.sv | 129 ++++++++++++
 tb/tb_gpu_command_queue.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_command_queue.sv
// Instruction FIFO between the CPU bus and the GPU. Queued words are issued to
// INS only on vertical-sync falling edges, and each one is held for FRAME_HOLD frames.
module gpu_command_queue #(
   parameter int DEPTH      = 16,
   parameter int FRAME_HOLD = 1
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     WR_EN,
   input  logic [31:0]              WR_DATA,
   input  logic                     V_SYNC,
   output logic [31:0]              INS,
   output logic                     FULL,
   output logic                     EMPTY,
   output logic [$clog2(DEPTH):0]   COUNT,
   output logic                     OVERFLOW
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic {IDLE, HOLD} state_t;

   state_t          r_state;
   state_t          w_stateNext;
   logic [31:0]     r_mem [DEPTH];
   logic [AW-1:0]   r_rdPtr;
   logic [AW-1:0]   r_wrPtr;
   logic [CW-1:0]   r_count;
   logic [7:0]      r_holdCnt;
   logic [7:0]      w_holdNext;
   logic [31:0]     r_ins;
   logic [31:0]     w_insNext;
   logic            r_vsQ;
   logic            r_ovf;
   logic            w_fe;
   logic            w_full;
   logic            w_empty;
   logic            w_push;
   logic            w_pop;

   // FULL and EMPTY come from the registered count, so a pop and a write in
   // the same cycle both see the occupancy from before that edge.
   assign w_fe    = r_vsQ & ~V_SYNC;
   assign w_full  = (r_count == CW'(DEPTH));
   assign w_empty = (r_count == '0);
   assign w_push  = WR_EN & ~w_full;

   always_ff @(posedge CLK) begin
      if (RST) r_state <= IDLE;
      else     r_state <= w_stateNext;
   end

   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         IDLE: if (w_fe && !w_empty) w_stateNext = HOLD;
         HOLD: if (w_fe && r_holdCnt == 8'd0 && w_empty) w_stateNext = IDLE;
         default: w_stateNext = IDLE;
      endcase
   end

   always_comb begin
      w_pop      = 1'b0;
      w_insNext  = r_ins;
      w_holdNext = r_holdCnt;
      if (w_fe) begin
         case (r_state)
            IDLE: begin
               if (!w_empty) begin
                  w_pop      = 1'b1;
                  w_insNext  = r_mem[r_rdPtr];
                  w_holdNext = 8'(FRAME_HOLD - 1);
               end else begin
                  w_insNext  = 32'd0;
               end
            end
            HOLD: begin
               if (r_holdCnt != 8'd0) begin
                  w_holdNext = r_holdCnt - 8'd1;
               end else if (!w_empty) begin
                  w_pop      = 1'b1;
                  w_insNext  = r_mem[r_rdPtr];
                  w_holdNext = 8'(FRAME_HOLD - 1);
               end else begin
                  w_insNext  = 32'd0;
               end
            end
            default: w_insNext = 32'd0;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_vsQ     <= 1'b1;
         r_rdPtr   <= '0;
         r_wrPtr   <= '0;
         r_count   <= '0;
         r_holdCnt <= 8'd0;
         r_ins     <= 32'd0;
         r_ovf     <= 1'b0;
      end else begin
         r_vsQ     <= V_SYNC;
         r_ins     <= w_insNext;
         r_holdCnt <= w_holdNext;
         if (w_push) r_wrPtr <= r_wrPtr + AW'(1);
         if (w_pop)  r_rdPtr <= r_rdPtr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         if (WR_EN && w_full) r_ovf <= 1'b1;
      end
   end

   // Storage has no reset; stale entries are unreachable once the pointers clear.
   always_ff @(posedge CLK) begin
      if (w_push) r_mem[r_wrPtr] <= WR_DATA;
   end

   assign INS      = r_ins;
   assign FULL     = w_full;
   assign EMPTY    = w_empty;
   assign COUNT    = r_count;
   assign OVERFLOW = r_ovf;

endmodule

// File: tb/tb_gpu_command_queue.sv
// Bench for gpu_command_queue: two instances (FRAME_HOLD 1 and 2) share stimulus
// and are compared every cycle against a queue-based frame model.
module tb_gpu_command_queue;

   localparam int DEPTH = 16;

   logic        CLK = 1'b0;
   logic        RST;
   logic        WR_EN;
   logic [31:0] WR_DATA;
   logic        V_SYNC;

   logic [31:0] ins1, ins2;
   logic        full1, full2, empty1, empty2, ovf1, ovf2;
   logic [4:0]  count1, count2;

   int checksRun    = 0;
   int checksPassed = 0;

   always #5 CLK = ~CLK;

   gpu_command_queue #(.DEPTH(DEPTH), .FRAME_HOLD(1)) u_dut1 (
      .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_DATA(WR_DATA), .V_SYNC(V_SYNC),
      .INS(ins1), .FULL(full1), .EMPTY(empty1), .COUNT(count1), .OVERFLOW(ovf1)
   );

   gpu_command_queue #(.DEPTH(DEPTH), .FRAME_HOLD(2)) u_dut2 (
      .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_DATA(WR_DATA), .V_SYNC(V_SYNC),
      .INS(ins2), .FULL(full2), .EMPTY(empty2), .COUNT(count2), .OVERFLOW(ovf2)
   );

   // Reference model: a plain queue per instance plus "frames left" for the
   // instruction on screen; index 0 is FRAME_HOLD=1, index 1 is FRAME_HOLD=2.
   logic [31:0] mq0[$];
   logic [31:0] mq1[$];
   logic [31:0] mIns  [2];
   logic        mBusy [2];
   int          mLeft [2];
   logic        mOvf  [2];
   logic        mVsPrev;
   int          holdOf [2] = '{1, 2};

   function automatic int qSize(input int k);
      return (k == 0) ? mq0.size() : mq1.size();
   endfunction

   task automatic qPush(input int k, input logic [31:0] d);
      if (k == 0) mq0.push_back(d);
      else        mq1.push_back(d);
   endtask

   task automatic qPop(input int k, output logic [31:0] d);
      if (k == 0) d = mq0.pop_front();
      else        d = mq1.pop_front();
   endtask

   task automatic modelStep(input logic rst, input logic wr, input logic [31:0] data, input logic vs);
      logic fe;
      logic doPop;
      int   size0;
      if (rst) begin
         mq0.delete();
         mq1.delete();
         for (int k = 0; k < 2; k++) begin
            mIns[k] = 32'd0; mBusy[k] = 1'b0; mLeft[k] = 0; mOvf[k] = 1'b0;
         end
         mVsPrev = 1'b1;
         return;
      end
      fe = mVsPrev && !vs;
      for (int k = 0; k < 2; k++) begin
         size0 = qSize(k);
         doPop = 1'b0;
         if (fe) begin
            if (!mBusy[k] || mLeft[k] == 1) begin
               if (size0 > 0) begin
                  doPop = 1'b1; mBusy[k] = 1'b1; mLeft[k] = holdOf[k];
               end else begin
                  mBusy[k] = 1'b0; mIns[k] = 32'd0;
               end
            end else begin
               mLeft[k] = mLeft[k] - 1;
            end
         end
         if (wr) begin
            if (size0 < DEPTH) qPush(k, data);
            else               mOvf[k] = 1'b1;
         end
         if (doPop) qPop(k, mIns[k]);
      end
      mVsPrev = vs;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checksRun++;
      if (act === exp) checksPassed++;
      else $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h at %0t", name, act, exp, $time);
   endtask

   task automatic checkOutput();
      check("ins1",   ins1,          mIns[0]);
      check("count1", 32'(count1),   32'(mq0.size()));
      check("full1",  32'(full1),    32'(mq0.size() == DEPTH));
      check("empty1", 32'(empty1),   32'(mq0.size() == 0));
      check("ovf1",   32'(ovf1),     32'(mOvf[0]));
      check("ins2",   ins2,          mIns[1]);
      check("count2", 32'(count2),   32'(mq1.size()));
      check("full2",  32'(full2),    32'(mq1.size() == DEPTH));
      check("empty2", 32'(empty2),   32'(mq1.size() == 0));
      check("ovf2",   32'(ovf2),     32'(mOvf[1]));
   endtask

   // Drive one cycle of inputs, let the edge happen, then compare 1 ns later.
   task automatic applyStimulus(input logic rst, input logic wr, input logic [31:0] data, input logic vs);
      RST = rst; WR_EN = wr; WR_DATA = data; V_SYNC = vs;
      @(posedge CLK);
      modelStep(rst, wr, data, vs);
      #1;
      checkOutput();
   endtask

   task automatic doReset();
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
   endtask

   task automatic pulse();
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
   endtask

   typedef struct {
      logic        rst;
      logic        wr;
      logic [31:0] data;
      logic        vs;
      logic [31:0] expIns2;
      int          expCount2;
   } vec_t;

   vec_t vecs[$];

   task automatic addVec(input logic rst, input logic wr, input logic [31:0] data, input logic vs,
                         input logic [31:0] expIns2, input int expCount2);
      vec_t v;
      v.rst = rst; v.wr = wr; v.data = data; v.vs = vs;
      v.expIns2 = expIns2; v.expCount2 = expCount2;
      vecs.push_back(v);
   endtask

   initial begin
      // Ordering and hold on the FRAME_HOLD=2 instance: 11,11,22,22,33,33,0.
      addVec(1, 0, 32'h0,  1, 32'h0,  0);
      addVec(0, 1, 32'h11, 1, 32'h0,  1);
      addVec(0, 1, 32'h22, 1, 32'h0,  2);
      addVec(0, 1, 32'h33, 1, 32'h0,  3);
      addVec(0, 0, 32'h0,  0, 32'h11, 2);
      addVec(0, 0, 32'h0,  1, 32'h11, 2);
      addVec(0, 0, 32'h0,  0, 32'h11, 2);
      addVec(0, 0, 32'h0,  1, 32'h11, 2);
      addVec(0, 0, 32'h0,  0, 32'h22, 1);
      addVec(0, 0, 32'h0,  1, 32'h22, 1);
      addVec(0, 0, 32'h0,  0, 32'h22, 1);
      addVec(0, 0, 32'h0,  1, 32'h22, 1);
      addVec(0, 0, 32'h0,  0, 32'h33, 0);
      addVec(0, 0, 32'h0,  1, 32'h33, 0);
      addVec(0, 0, 32'h0,  0, 32'h33, 0);
      addVec(0, 0, 32'h0,  1, 32'h33, 0);
      addVec(0, 0, 32'h0,  0, 32'h0,  0);
      addVec(0, 0, 32'h0,  1, 32'h0,  0);

      // Reset with an idle queue: nothing issues on three frames.
      doReset();
      check("rst_ins", ins1, 32'h0);
      check("rst_empty", 32'(empty1), 32'd1);
      for (int i = 0; i < 3; i++) begin
         pulse();
         check("idle_ins2", ins2, 32'h0);
         check("idle_count1", 32'(count1), 32'd0);
      end

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].rst, vecs[i].wr, vecs[i].data, vecs[i].vs);
         check("vec_ins2", ins2, vecs[i].expIns2);
         check("vec_count2", 32'(count2), 32'(vecs[i].expCount2));
      end

      // Single instruction with FRAME_HOLD=1.
      doReset();
      applyStimulus(1'b0, 1'b1, 32'hA5A5_0001, 1'b1);
      check("single_count_before", 32'(count1), 32'd1);
      pulse();
      check("single_ins", ins1, 32'hA5A5_0001);
      check("single_count_after", 32'(count1), 32'd0);
      pulse();
      check("single_back_to_nop", ins1, 32'h0);

      // Fill past capacity, then drain in order.
      doReset();
      for (int i = 0; i < 17; i++) begin
         applyStimulus(1'b0, 1'b1, 32'(i), 1'b1);
         if (i == 15) begin
            check("full_flag", 32'(full1), 32'd1);
            check("full_count", 32'(count1), 32'd16);
            check("no_ovf_yet", 32'(ovf1), 32'd0);
         end
      end
      check("overflow", 32'(ovf1), 32'd1);
      check("count_after_drop", 32'(count1), 32'd16);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
         check("drain_order", ins1, 32'(i));
         applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
      end
      pulse();
      check("drain_done", ins1, 32'h0);
      check("ovf_sticky", 32'(ovf1), 32'd1);

      // Write into an empty queue on the frame edge misses that edge.
      doReset();
      applyStimulus(1'b0, 1'b1, 32'h0000_C0DE, 1'b0);
      check("fe_write_empty_ins", ins1, 32'h0);
      check("fe_write_empty_count", 32'(count1), 32'd1);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
      check("fe_write_issues_next", ins1, 32'h0000_C0DE);

      // Write on the frame edge while full is dropped even though a pop happens.
      doReset();
      for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, 32'h100 + 32'(i), 1'b1);
      applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
      check("fe_full_head", ins1, 32'h100);
      check("fe_full_count", 32'(count1), 32'd15);
      check("fe_full_ovf", 32'(ovf1), 32'd1);

      // Reset in the middle of a held frame discards everything.
      doReset();
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 32'h200 + 32'(i), 1'b1);
      pulse();
      check("mid_count", 32'(count2), 32'd5);
      check("mid_ins", ins2, 32'h200);
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
      check("mid_rst_ins", ins2, 32'h0);
      check("mid_rst_count", 32'(count2), 32'd0);
      pulse();
      check("mid_rst_no_issue", ins2, 32'h0);

      // Randomized traffic against the model.
      doReset();
      for (int i = 0; i < 2000; i++) begin
         applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1),
                       $urandom, ($urandom_range(0, 3) != 0));
      end

      $display("[TB] %0d/%0d checks passed", checksPassed, checksRun);
      $finish;
   end

endmodule
